// File: rtl/bmc_accum_hist.sv
// Odd-accumulator with a circular history memory and selectable tap modes.
// Each enabled step logs the counter, then adds one tapped history entry and an odd increment.
module bmc_accum_hist #(
  parameter int DW      = 8,
  parameter int AW      = 5,
  parameter int IW      = 2,
  parameter int DEF_VAL = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [IW-1:0] inc_sel,
  input  logic [AW-1:0] rd_idx,
  output logic [DW-1:0] counter_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] tap_o,
  output logic          tap_hit_o,
  output logic          wrapped_o,
  output logic          prop_ok_o,
  output logic          fail_o
);

  localparam int            DEPTH     = 1 << AW;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [DW-1:0] DEF_W     = DW'(DEF_VAL);

  localparam logic [1:0] MODE_HALF   = 2'd0;
  localparam logic [1:0] MODE_PREV   = 2'd1;
  localparam logic [1:0] MODE_OLDEST = 2'd2;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] wr_sel;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    counter_q, counter_d;
  logic             wrapped_q, wrapped_d;
  logic             fail_q, fail_d;
  logic [AW-1:0]    tap_idx;
  logic [DW-1:0]    t2;

  always_comb begin
    case (mode)
      MODE_HALF:   tap_idx = addr_q >> 1;
      MODE_PREV:   tap_idx = addr_q - ADDR_ONE;
      MODE_OLDEST: tap_idx = addr_q + ADDR_ONE;
      default:     tap_idx = rd_idx;
    endcase
  end

  // Asynchronous read sees pre-write contents, so a tap at addr_q reads the old entry.
  assign tap_hit_o = valid_q[tap_idx];
  assign tap_o     = tap_hit_o ? mem_q[tap_idx] : DEF_W;
  assign t2        = DW'({inc_sel, 1'b1});

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign wr_sel[gi] = en && (addr_q == AW'(gi));
    end
  endgenerate

  always_comb begin
    counter_d = counter_q;
    addr_d    = addr_q;
    wrapped_d = wrapped_q;
    valid_d   = valid_q | wr_sel;
    fail_d    = fail_q | ~counter_q[0];
    if (en) begin
      counter_d = counter_q + tap_o + t2;
      addr_d    = addr_q + ADDR_ONE;
      if (addr_q == ADDR_LAST) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      counter_q <= DW'(1);
      valid_q   <= '0;
      wrapped_q <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      counter_q <= counter_d;
      valid_q   <= valid_d;
      wrapped_q <= wrapped_d;
      fail_q    <= fail_d;
    end
  end

  // Contents survive reset; the valid bits hide stale entries.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem_q[addr_q] <= counter_q;
    end
  end

  assign counter_o = counter_q;
  assign addr_o    = addr_q;
  assign wrapped_o = wrapped_q;
  assign prop_ok_o = counter_q[0];
  assign fail_o    = fail_q;

endmodule

// File: tb/tb_bmc_accum_hist.sv
// Directed and random checks of bmc_accum_hist against an integer model of its step rules,
// plus a second instance built with an even default tap to exercise the sticky failure flag.
module tb_bmc_accum_hist;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int IW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [IW-1:0] inc_sel = '0;
  logic [AW-1:0] rd_idx = '0;
  logic [DW-1:0] counter_o, tap_o;
  logic [AW-1:0] addr_o;
  logic          tap_hit_o, wrapped_o, prop_ok_o, fail_o;

  logic          b_rst = 1'b1, b_en = 1'b0;
  logic [1:0]    b_mode = 2'd0;
  logic [IW-1:0] b_inc = '0;
  logic [AW-1:0] b_rd = '0;
  logic [DW-1:0] b_counter, b_tap;
  logic [AW-1:0] b_addr;
  logic          b_hit, b_wrapped, b_prop, b_fail;

  bmc_accum_hist #(.DW(DW), .AW(AW), .IW(IW), .DEF_VAL(13)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .inc_sel(inc_sel), .rd_idx(rd_idx),
    .counter_o(counter_o), .addr_o(addr_o), .tap_o(tap_o), .tap_hit_o(tap_hit_o),
    .wrapped_o(wrapped_o), .prop_ok_o(prop_ok_o), .fail_o(fail_o)
  );

  bmc_accum_hist #(.DW(DW), .AW(AW), .IW(IW), .DEF_VAL(12)) dut_even (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .inc_sel(b_inc), .rd_idx(b_rd),
    .counter_o(b_counter), .addr_o(b_addr), .tap_o(b_tap), .tap_hit_o(b_hit),
    .wrapped_o(b_wrapped), .prop_ok_o(b_prop), .fail_o(b_fail)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp,
                     input bit verbose);
    n_total++;
    if (got === exp) begin
      n_pass++;
      if (verbose) $display("[%0t] %s ok got=%0d exp=%0d", $time, name, got, exp);
    end else begin
      $display("[%0t] FAIL %s got=%0d exp=%0d", $time, name, got, exp);
    end
  endtask

  // Model of the DEF_VAL=13 instance: plain integer arithmetic modulo 2**DW and DEPTH.
  int m_mem [DEPTH];
  bit m_valid [DEPTH];
  int m_addr = 0;
  int m_cnt = 1;
  bit m_wrapped = 1'b0;
  bit m_fail = 1'b0;

  function automatic void model_tap(input int md, input int ri, output int t, output bit h);
    int idx;
    case (md)
      0:       idx = m_addr / 2;
      1:       idx = (m_addr + DEPTH - 1) % DEPTH;
      2:       idx = (m_addr + 1) % DEPTH;
      default: idx = ri;
    endcase
    h = m_valid[idx];
    t = h ? m_mem[idx] : 13;
  endfunction

  always @(posedge clk) begin : model_upd
    int t;
    bit h;
    if (rst) begin
      m_addr = 0;
      m_cnt = 1;
      m_wrapped = 1'b0;
      m_fail = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    end else begin
      model_tap(int'(mode), int'(rd_idx), t, h);
      if (m_cnt % 2 == 0) m_fail = 1'b1;
      if (en) begin
        m_mem[m_addr] = m_cnt;
        m_valid[m_addr] = 1'b1;
        if (m_addr == DEPTH - 1) m_wrapped = 1'b1;
        m_cnt = (m_cnt + t + 2 * int'(inc_sel) + 1) % 256;
        m_addr = (m_addr + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin : cmp
      int t;
      bit h;
      model_tap(int'(mode), int'(rd_idx), t, h);
      chk("m_counter", counter_o, m_cnt, 1'b0);
      chk("m_addr", addr_o, m_addr, 1'b0);
      chk("m_tap", tap_o, t, 1'b0);
      chk("m_hit", tap_hit_o, h, 1'b0);
      chk("m_wrapped", wrapped_o, m_wrapped, 1'b0);
      chk("m_prop", prop_ok_o, m_cnt % 2, 1'b0);
      chk("m_fail", fail_o, m_fail, 1'b0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int hold_tap [3] = '{17, 21, 13};

  initial begin
    tick();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_counter", counter_o, 1, 1'b1);
    chk("rst_addr", addr_o, 0, 1'b1);
    chk("rst_wrapped", wrapped_o, 0, 1'b1);
    chk("rst_fail", fail_o, 0, 1'b1);

    // PREV accumulation
    en = 1'b1; mode = 2'd1; inc_sel = 2'd1;
    #1;
    chk("prev0_tap", tap_o, 13, 1'b1);
    chk("prev0_hit", tap_hit_o, 0, 1'b1);
    tick();
    chk("prev0_counter", counter_o, 17, 1'b1);
    chk("prev1_tap", tap_o, 1, 1'b1);
    chk("prev1_hit", tap_hit_o, 1, 1'b1);
    tick();
    chk("prev1_counter", counter_o, 21, 1'b1);
    chk("prev2_tap", tap_o, 17, 1'b1);
    tick();
    chk("prev2_counter", counter_o, 41, 1'b1);
    chk("prev2_addr", addr_o, 3, 1'b1);

    // Hold with inputs toggling
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode = 2'(i % 3);
      inc_sel = 2'(i);
      tick();
      chk("hold_counter", counter_o, 41, 1'b1);
      chk("hold_addr", addr_o, 3, 1'b1);
      chk("hold_tap", tap_o, hold_tap[i % 3], 1'b1);
    end

    // Wrap
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; mode = 2'd1; inc_sel = 2'd0;
    tick(31);
    chk("wrap31_addr", addr_o, 31, 1'b1);
    chk("wrap31_wrapped", wrapped_o, 0, 1'b1);
    tick();
    chk("wrap32_addr", addr_o, 0, 1'b1);
    chk("wrap32_wrapped", wrapped_o, 1, 1'b1);
    en = 1'b0; mode = 2'd2;
    #1;
    chk("oldest_hit", tap_hit_o, 1, 1'b1);
    chk("oldest_tap", tap_o, 15, 1'b1);

    // ABS
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; mode = 2'd1; inc_sel = 2'd1;
    tick(4);
    chk("abs_counter", counter_o, 65, 1'b1);
    en = 1'b0; mode = 2'd3; rd_idx = 5'd31;
    #1;
    chk("abs31_tap", tap_o, 13, 1'b1);
    chk("abs31_hit", tap_hit_o, 0, 1'b1);
    rd_idx = 5'd2;
    #1;
    chk("abs2_tap", tap_o, 21, 1'b1);
    chk("abs2_hit", tap_hit_o, 1, 1'b1);

    // Reset mid-operation with en held high
    mode = 2'd1; en = 1'b1;
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    chk("midrst_counter", counter_o, 1, 1'b1);
    chk("midrst_addr", addr_o, 0, 1'b1);
    chk("midrst_wrapped", wrapped_o, 0, 1'b1);
    #1;
    chk("midrst_tap", tap_o, 13, 1'b1);
    chk("midrst_hit", tap_hit_o, 0, 1'b1);

    // Random stress of the odd-accumulator property
    for (int i = 0; i < 2000; i++) begin
      en = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      inc_sel = 2'($urandom_range(0, 3));
      rd_idx = 5'($urandom_range(0, 31));
      tick();
      chk("rand_prop", prop_ok_o, 1, 1'b0);
      chk("rand_fail", fail_o, 0, 1'b0);
    end
    chk("rand_end_fail", fail_o, 0, 1'b1);

    // Even default tap breaks the property
    tick();
    b_rst = 1'b0; b_en = 1'b1; b_mode = 2'd1; b_inc = 2'd1;
    tick();
    chk("even_counter", b_counter, 16, 1'b1);
    chk("even_prop", b_prop, 0, 1'b1);
    chk("even_fail_lag", b_fail, 0, 1'b1);
    b_en = 1'b0;
    tick();
    chk("even_fail_set", b_fail, 1, 1'b1);
    tick(3);
    chk("even_fail_sticky", b_fail, 1, 1'b1);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    chk("even_rst_fail", b_fail, 0, 1'b1);
    chk("even_rst_counter", b_counter, 1, 1'b1);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bmc_accum_hist.md
Name: bmc_accum_hist

Overview:
- Parametrised accumulator with history memory; the next-generation model-checking target for the bmctests suite.
- Each enabled cycle it:
  - writes the current accumulator value into a circular history memory;
  - reads back one history entry through a selectable tap mode;
  - adds that entry plus an odd increment to the accumulator.
- Exposes the odd-accumulator safety property as both a live flag and a sticky failure flag, for simulation benches and formal harnesses.
- Adds enable, per-entry valid tracking, wrap detection and four tap modes.

Parameters:
DW, 8, accumulator/memory data width
AW, 5, address width; history depth = 2**AW
IW, 2, increment-select width; IW+1 <= DW
DEF_VAL, 13, tap value returned for an unwritten entry; must be odd for the property to hold

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  step enable
mode  input  2  tap mode: 0 HALF, 1 PREV, 2 OLDEST, 3 ABS
inc_sel  input  IW  increment select
rd_idx  input  AW  tap index for ABS mode
counter_o  output  DW  accumulator
addr_o  output  AW  write pointer
tap_o  output  DW  current tap value (combinational)
tap_hit_o  output  1  tap entry valid (combinational)
wrapped_o  output  1  write pointer has wrapped at least once
prop_ok_o  output  1  counter_o[0] (combinational)
fail_o  output  1  sticky property failure

Behaviour:
- Reset, when rst=1 at a clock edge, has priority over en:
  - addr=0, counter=1, all 2**AW valid bits=0, wrapped=0, fail=0.
  - Memory contents are not cleared; the valid bits mask them.
- Tap index, from current state:
  - HALF = addr>>1
  - PREV = addr-1 (mod 2**AW)
  - OLDEST = addr+1 (mod 2**AW)
  - ABS = rd_idx
- Tap value:
  - tap_hit_o = valid[idx].
  - tap_o = mem[idx] if hit, else DEF_VAL.
  - Read-before-write: a tap at idx==addr sees the pre-write contents and valid bit.
- Increment: t2 = 2*inc_sel+1, zero-extended to DW, so it is always odd.
- Step, when en=1 and rst=0:
  - mem[addr] <= counter
  - valid[addr] <= 1
  - addr <= addr+1 (wraps mod 2**AW)
  - counter <= counter + tap_o + t2, truncated to DW bits
  - wrapped <= 1 when addr==2**AW-1
- Hold, when en=0 and rst=0: addr, counter, memory, valid bits and wrapped are all unchanged.
- fail:
  - fail <= fail | ~counter[0] on every non-reset edge, independent of en.
  - Sets one cycle after counter goes even; stays set until rst.
- Invariant with odd DEF_VAL:
  - counter, every stored entry, tap_o and t2 are always odd.
  - Therefore prop_ok_o=1 and fail_o=0 in all reachable states.
- Latency:
  - counter_o/addr_o update one edge after en.
  - tap_o/tap_hit_o follow state and inputs combinationally.
- Memory is a plain register array with one write and one asynchronous read; no RAM macro.
- Inputs changing while en=0 have no effect on state.

Test Plan:
- PREV accumulation, DEF_VAL=13: reset, then en=1, mode=1, inc_sel=1 (t2=3).
  - cycle0: tap 13, hit=0 -> counter=17, mem[0]=1
  - cycle1: tap 1, hit=1 -> counter=21
  - cycle2: tap 17 -> counter=41; addr_o=3
- Hold: after the PREV scenario, en=0 for 5 cycles with mode and inc_sel toggling -> counter_o=41, addr_o=3 unchanged; tap_o changes only with mode.
- Wrap: AW=5, en=1 for 32 cycles -> addr_o=0 and wrapped_o=1 after edge 32; mode=2 now gives tap_hit_o=1, tap_o=mem[1].
- ABS: 4 steps, then mode=3.
  - rd_idx=31 -> tap_o=13, hit=0.
  - rd_idx=2 -> tap_o equals the counter value written at step 2, hit=1.
- Reset mid-operation: 10 steps, rst=1 for one edge with en=1 -> counter_o=1, addr_o=0, wrapped_o=0; PREV tap returns 13 with hit=0.
- Property:
  - 2000 random cycles of en/mode/inc_sel/rd_idx -> prop_ok_o=1 and fail_o=0 throughout.
  - Build with DEF_VAL=12: first step at mode=1, inc_sel=1 gives counter=16; fail_o=1 the following cycle and it stays set until rst.
